exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/exec_ctrl.sv | 99 +++++++++
 tb/tb_exec_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-cycle-step execution controller:
// FSM encoding, default latencies and counter widths.
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    MEM    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int FETCH_LAT_DEF = 1;
  localparam int MEM_LAT_DEF   = 1;
  localparam int CNT_W         = 32;
  localparam int LAT_W         = 2;
endpackage

// File: rtl/exec_ctrl.sv
// Execution controller: sequences FETCH/MEM/COMMIT per instruction, with
// single-step, continuous-run and PC breakpoint support.
module exec_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int FETCH_LAT = FETCH_LAT_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             run_tgl,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             mem_ren,
  input  logic             mem_wen,
  output logic             pc_wen,
  output logic             reg_wen_en,
  output logic             ram_wen,
  output logic             running,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state
);
  localparam logic [LAT_W-1:0] FETCH_LD = LAT_W'(FETCH_LAT - 1);
  localparam logic [LAT_W-1:0] MEM_LD   = LAT_W'(MEM_LAT - 1);

  state_t           cur, nxt;
  logic [LAT_W-1:0] cnt;
  logic             run_q, bp_q, fresh;
  logic [CNT_W-1:0] ret_q;
  logic             lat_done, fetch_first, hit, run_d, launch;

  assign lat_done    = (cnt == '0);
  assign fetch_first = (cur == FETCH) && (cnt == FETCH_LD);
  // The first fetch after leaving IDLE never halts, so a resumed run can
  // execute the instruction sitting on the breakpoint.
  assign hit    = fetch_first && run_q && bp_en && (pc == bp_addr) && !fresh;
  assign launch = (cur == IDLE) && (nxt == FETCH);

  // Running mode after this cycle; a breakpoint hit overrides any toggle.
  always_comb begin
    run_d = run_q;
    if (hit)          run_d = 1'b0;
    else if (run_tgl) run_d = !run_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:   if (run_d || (step && !run_q)) nxt = FETCH;
      FETCH: begin
        if (hit)           nxt = IDLE;
        else if (lat_done) nxt = mem_ren ? MEM : COMMIT;
      end
      MEM:    if (lat_done) nxt = COMMIT;
      COMMIT: nxt = run_d ? FETCH : IDLE;
    endcase
  end

  always_comb begin
    pc_wen     = (cur == COMMIT);
    reg_wen_en = (cur == COMMIT);
    ram_wen    = (cur == COMMIT) && mem_wen;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      run_q <= 1'b0;
      bp_q  <= 1'b0;
      fresh <= 1'b0;
      ret_q <= '0;
    end else begin
      run_q <= run_d;
      if (hit)         bp_q <= 1'b1;
      else if (launch) bp_q <= 1'b0;
      if (launch)                           fresh <= 1'b1;
      else if (cur == FETCH && nxt != FETCH) fresh <= 1'b0;
      if (cur == COMMIT) ret_q <= ret_q + 1'b1;
      // One down-counter serves both FETCH and MEM; reloaded on phase entry.
      if (nxt == FETCH && cur != FETCH)      cnt <= FETCH_LD;
      else if (nxt == MEM && cur != MEM)     cnt <= MEM_LD;
      else if (nxt == cur && !lat_done)      cnt <= cnt - 1'b1;
      else                                   cnt <= '0;
    end
  end

  assign state   = cur;
  assign running = run_q;
  assign bp_hit  = bp_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed vector table, hand sequences for run/break/
// reset/wrap corners, and random stimulus against an instruction-level model.
module tb_exec_ctrl;
  logic        clk, rst_n, step, run_tgl, bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_a [2];
  logic        ren_a [2], wen_a [2];
  logic        o_pcw [2], o_regw [2], o_ramw [2], o_run [2], o_bp [2];
  logic [31:0] o_ret [2];
  logic [1:0]  o_st [2];

  int n_chk = 0, n_pass = 0;
  bit auto_mem = 1'b0;
  logic [1:0] ptab [16];

  logic        cap_step, cap_tgl, cap_bpen, cap_rst;
  logic [31:0] cap_bpa;
  logic [31:0] cap_pc [2];
  logic        cap_ren [2];

  int          m_ph [2], m_left [2];
  bit          m_run [2], m_bp [2], m_fresh [2];
  logic [31:0] m_ret [2];
  int          FL [2] = '{1, 3};
  int          ML [2] = '{1, 2};

  exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run_tgl(run_tgl), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc_a[0]), .mem_ren(ren_a[0]), .mem_wen(wen_a[0]),
    .pc_wen(o_pcw[0]), .reg_wen_en(o_regw[0]), .ram_wen(o_ramw[0]),
    .running(o_run[0]), .bp_hit(o_bp[0]), .retired(o_ret[0]), .state(o_st[0])
  );

  exec_ctrl #(.FETCH_LAT(3), .MEM_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .step(step), .run_tgl(run_tgl), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc_a[1]), .mem_ren(ren_a[1]), .mem_wen(wen_a[1]),
    .pc_wen(o_pcw[1]), .reg_wen_en(o_regw[1]), .ram_wen(o_ramw[1]),
    .running(o_run[1]), .bp_hit(o_bp[1]), .retired(o_ret[1]), .state(o_st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stp, tgl, ren, wen;
    logic [1:0]  st;
    logic        pcw, ramw, run;
    logic [31:0] ret;
  } vec_t;

  function automatic vec_t mk(input logic s, t, r, w, input logic [1:0] st,
                              input logic pcw, ramw, run, input logic [31:0] ret);
    vec_t v;
    v.stp = s; v.tgl = t; v.ren = r; v.wen = w; v.st = st;
    v.pcw = pcw; v.ramw = ramw; v.run = run; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock; the bench PC register advances on the DUT's pc_wen.
  task automatic tick();
    logic pcw [2];
    cap_step = step; cap_tgl = run_tgl; cap_bpen = bp_en; cap_bpa = bp_addr; cap_rst = rst_n;
    for (int i = 0; i < 2; i++) begin
      cap_pc[i] = pc_a[i]; cap_ren[i] = ren_a[i]; pcw[i] = o_pcw[i];
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (!cap_rst)    pc_a[i] = 32'h0;
      else if (pcw[i]) pc_a[i] = (pc_a[i] + 32'd4) & 32'h3F;
      if (auto_mem) {ren_a[i], wen_a[i]} = ptab[pc_a[i][5:2]];
    end
    step = 1'b0; run_tgl = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic fill_prog(input logic [1:0] k);
    for (int i = 0; i < 16; i++) ptab[i] = k;
    for (int i = 0; i < 2; i++) {ren_a[i], wen_a[i]} = ptab[pc_a[i][5:2]];
  endtask

  task automatic wait_st(input string nm, input logic [1:0] s, input int max);
    int k = 0;
    while (o_st[0] !== s && k < max) begin tick(); k++; end
    chk(nm, {62'd0, o_st[0]}, {62'd0, s});
  endtask

  // Instruction-level reference: phase number plus cycles remaining in it.
  task automatic model_step(input int i);
    bit run_n, hit;
    if (!cap_rst) begin
      m_ph[i] = 0; m_left[i] = 0; m_run[i] = 0; m_bp[i] = 0; m_fresh[i] = 0; m_ret[i] = 0;
      return;
    end
    run_n = cap_tgl ? !m_run[i] : m_run[i];
    case (m_ph[i])
      0: begin
        if (run_n || (cap_step && !m_run[i])) begin
          m_ph[i] = 1; m_left[i] = FL[i]; m_bp[i] = 0; m_fresh[i] = 1;
        end
        m_run[i] = run_n;
      end
      1: begin
        hit = (m_left[i] == FL[i]) && m_run[i] && cap_bpen && (cap_pc[i] == cap_bpa) && !m_fresh[i];
        if (hit) begin
          m_ph[i] = 0; m_run[i] = 0; m_bp[i] = 1;
        end else begin
          m_run[i] = run_n;
          if (m_left[i] > 1) m_left[i]--;
          else begin
            m_fresh[i] = 0;
            if (cap_ren[i]) begin m_ph[i] = 2; m_left[i] = ML[i]; end
            else m_ph[i] = 3;
          end
        end
      end
      2: begin
        m_run[i] = run_n;
        if (m_left[i] > 1) m_left[i]--; else m_ph[i] = 3;
      end
      default: begin
        m_run[i] = run_n;
        m_ret[i] = m_ret[i] + 32'd1;
        if (run_n) begin m_ph[i] = 1; m_left[i] = FL[i]; end
        else m_ph[i] = 0;
      end
    endcase
  endtask

  vec_t tab [14];
  logic [38:0] act_v, exp_v;
  int ram_cnt, bad;

  initial begin
    rst_n = 1'b0; step = 1'b0; run_tgl = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
    for (int i = 0; i < 2; i++) begin pc_a[i] = 32'h0; ren_a[i] = 1'b0; wen_a[i] = 1'b0; end
    for (int i = 0; i < 16; i++) ptab[i] = 2'b00;

    tick(); tick();
    chk("reset_outputs_zero", {25'd0, o_st[0], o_pcw[0], o_regw[0], o_ramw[0], o_run[0], o_bp[0], o_ret[0]}, 64'd0);
    rst_n = 1'b1;

    // lw, add, sw single steps; step during FETCH ignored.
    tab[0]  = mk(1, 0, 1, 0, 2'd1, 0, 0, 0, 32'd0);
    tab[1]  = mk(0, 0, 1, 0, 2'd2, 0, 0, 0, 32'd0);
    tab[2]  = mk(0, 0, 1, 0, 2'd3, 1, 0, 0, 32'd0);
    tab[3]  = mk(0, 0, 1, 0, 2'd0, 0, 0, 0, 32'd1);
    tab[4]  = mk(1, 0, 0, 0, 2'd1, 0, 0, 0, 32'd1);
    tab[5]  = mk(0, 0, 0, 0, 2'd3, 1, 0, 0, 32'd1);
    tab[6]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 32'd2);
    tab[7]  = mk(1, 0, 0, 1, 2'd1, 0, 0, 0, 32'd2);
    tab[8]  = mk(0, 0, 0, 1, 2'd3, 1, 1, 0, 32'd2);
    tab[9]  = mk(0, 0, 0, 1, 2'd0, 0, 0, 0, 32'd3);
    tab[10] = mk(1, 0, 0, 0, 2'd1, 0, 0, 0, 32'd3);
    tab[11] = mk(1, 0, 0, 0, 2'd3, 1, 0, 0, 32'd3);
    tab[12] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 32'd4);
    tab[13] = mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 32'd4);
    auto_mem = 1'b0;
    for (int r = 0; r < 14; r++) begin
      step = tab[r].stp; run_tgl = tab[r].tgl; ren_a[0] = tab[r].ren; wen_a[0] = tab[r].wen;
      tick();
      act_v = {o_st[0], o_pcw[0], o_regw[0], o_ramw[0], o_run[0], 1'b0, o_ret[0]};
      exp_v = {tab[r].st, tab[r].pcw, tab[r].pcw, tab[r].ramw, tab[r].run, 1'b0, tab[r].ret};
      chk($sformatf("vec%0d", r), {25'd0, act_v}, {25'd0, exp_v});
    end
    auto_mem = 1'b1;

    // Run into a breakpoint at 0x10, then resume past it.
    do_reset(); fill_prog(2'b00); bp_en = 1'b1; bp_addr = 32'h10;
    run_tgl = 1'b1; tick();
    wait_st("bp_reach_idle", 2'd0, 60);
    chk("bp_pc", pc_a[0], 32'h10);
    chk("bp_retired", o_ret[0], 32'd4);
    chk("bp_flags", {62'd0, o_bp[0], o_run[0]}, 64'b10);
    run_tgl = 1'b1; tick();
    for (int k = 0; k < 20 && pc_a[0] != 32'h14; k++) tick();
    chk("bp_resume_pc", pc_a[0], 32'h14);
    chk("bp_resume_flags", {62'd0, o_bp[0], o_run[0]}, 64'b01);
    run_tgl = 1'b1; tick();
    wait_st("bp_stop_idle", 2'd0, 20);
    chk("bp_stop_retired", o_ret[0], 32'd6);
    bp_en = 1'b0;

    // Store at 0x8 in run mode: ram_wen only in its COMMIT.
    do_reset(); fill_prog(2'b00); ptab[2] = 2'b01;
    run_tgl = 1'b1; tick();
    ram_cnt = 0; bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (o_ramw[0]) ram_cnt++;
      if (o_ramw[0] !== (o_pcw[0] && pc_a[0] == 32'h8)) bad++;
      tick();
    end
    chk("sw_ram_cycles", ram_cnt, 1);
    chk("sw_ram_only_commit", bad, 0);
    run_tgl = 1'b1; tick();
    wait_st("sw_stop_idle", 2'd0, 20);

    // run_tgl during MEM while running: finish through COMMIT, then IDLE.
    do_reset(); fill_prog(2'b10);
    run_tgl = 1'b1; tick(); tick(); tick();
    wait_st("mem_reach", 2'd2, 20);
    run_tgl = 1'b1; tick();
    chk("mem_tgl_commit", {61'd0, o_st[0], o_run[0]}, {61'd0, 2'd3, 1'b0});
    tick();
    chk("mem_tgl_idle", {62'd0, o_st[0]}, 64'd0);

    // step together with run_tgl in IDLE acts as run_tgl.
    do_reset(); fill_prog(2'b00);
    step = 1'b1; run_tgl = 1'b1; tick();
    chk("step_tgl_run", {61'd0, o_st[0], o_run[0]}, {61'd0, 2'd1, 1'b1});
    run_tgl = 1'b1; tick();
    wait_st("step_tgl_stop", 2'd0, 20);

    // Reset in the cycle before COMMIT aborts the instruction.
    do_reset(); fill_prog(2'b00);
    step = 1'b1; tick(); tick(); tick();
    chk("pre_rst_retired", o_ret[0], 32'd1);
    fill_prog(2'b10);
    step = 1'b1; tick();
    wait_st("rst_reach_mem", 2'd2, 10);
    rst_n = 1'b0; tick();
    chk("rst_mid_outputs", {25'd0, o_st[0], o_pcw[0], o_regw[0], o_ramw[0], o_run[0], o_bp[0], o_ret[0]}, 64'd0);
    rst_n = 1'b1; tick();
    chk("rst_after_pcw", {61'd0, o_st[0], o_pcw[0]}, 64'd0);

    // retired wraps from all-ones to zero.
    force dut.ret_q = 32'hFFFF_FFFF;
    #1 release dut.ret_q;
    chk("wrap_forced", o_ret[0], 32'hFFFF_FFFF);
    fill_prog(2'b00);
    step = 1'b1; tick();
    wait_st("wrap_idle", 2'd0, 10);
    chk("wrap_zero", o_ret[0], 32'd0);

    // Random stimulus on both latency configurations.
    for (int i = 0; i < 16; i++) ptab[i] = 2'($urandom_range(0, 3));
    rst_n = 1'b0; tick();
    for (int i = 0; i < 2; i++) model_step(i);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step    = ($urandom_range(0, 5) == 0);
      run_tgl = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 40) == 0) begin
        bp_en   = ($urandom_range(0, 2) != 0);
        bp_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        model_step(i);
        act_v = {o_st[i], o_pcw[i], o_regw[i], o_ramw[i], o_run[i], o_bp[i], o_ret[i]};
        exp_v = {2'(m_ph[i]), m_ph[i] == 3, m_ph[i] == 3, (m_ph[i] == 3) && wen_a[i],
                 m_run[i], m_bp[i], m_ret[i]};
        chk($sformatf("rand_i%0d_c%0d", i, c), {25'd0, act_v}, {25'd0, exp_v});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
